control_unit_p: RTL

Parametrised multi-cycle control sequencer for the bus-based processor datapath. It fetches an instruction word from the data-input port into IR, decodes the opcode and register fields, and steps the shared bus through source/destination transfers for move, move-immediate and ALU instructions. Compared with the fixed 9-bit unit, it adds the following:
- parametrised field widths;
- a programmable clocks-per-step divider;
- a din_valid/din_ack fetch handshake;
- an explicit bus-enable in place of a tri-stated value;
- an instruction-done pulse.

---
 rtl/control_unit_p.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_p.sv
// control_unit_p: multi-cycle control sequencer for the bus-based datapath.
// Fetches an instruction from the data-input port into IR, decodes it, and
// steps the shared bus through the source/destination transfers for mv, mvi
// and ALU instructions. Every state lasts STEP_DIV clocks, and all bus
// outputs are registered.
//
// Handshake: din_valid means the data-input port holds a valid word. The
// fetch (F_SRC) and immediate (IMM_SRC) steps sample din_valid only on the
// last clock of the step. If din_valid is 1 there, the step exits, and din_ack
// is 1 during that same clock, so the producer can retire the word on that
// edge. If din_valid is 0 there, the step repeats with its outputs unchanged.
module control_unit_p #(
  parameter int OP_BITS  = 3,
  parameter int REG_BITS = 3,
  parameter int STEP_DIV = 2,
  localparam int IR_W    = OP_BITS + 2 * REG_BITS,
  localparam int ADDR_W  = REG_BITS + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   ir,
  input  logic              din_valid,
  output logic              din_ack,
  output logic [ADDR_W-1:0] addr,
  output logic              val,
  output logic              bus_en,
  output logic [OP_BITS-1:0] opcode,
  output logic              aluen,
  output logic              instr_done,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_SRC   = 4'd1,
    S_F_LD    = 4'd2,
    S_DECODE  = 4'd3,
    S_IMM_SRC = 4'd4,
    S_IMM_LD  = 4'd5,
    S_A_SRC   = 4'd6,
    S_A_LD    = 4'd7,
    S_OP_SRC  = 4'd8,
    S_EXEC    = 4'd9,
    S_G_SRC   = 4'd10,
    S_WB_LD   = 4'd11
  } state_t;

  // Step counter width; a divider of 1 still gets a 1-bit counter that stays 0.
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  // Special bus addresses sit just above the GPR range.
  localparam logic [ADDR_W-1:0] ADDR_DIN = ADDR_W'(1 << REG_BITS);
  localparam logic [ADDR_W-1:0] ADDR_A   = ADDR_W'((1 << REG_BITS) + 1);
  localparam logic [ADDR_W-1:0] ADDR_G   = ADDR_W'((1 << REG_BITS) + 2);
  localparam logic [ADDR_W-1:0] ADDR_IR  = ADDR_W'((1 << REG_BITS) + 3);

  localparam logic [OP_BITS-1:0] OP_MV  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_MVI = OP_BITS'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_BITS-1:0] rx_q, rx_d;
  logic [REG_BITS-1:0] ry_q, ry_d;
  logic [OP_BITS-1:0]  opcode_q, opcode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                val_q, val_d;
  logic                bus_en_q, bus_en_d;
  logic                aluen_q, aluen_d;
  logic                done_q, done_d;

  logic                step_last;
  logic                wait_state;
  logic                advance;
  logic [OP_BITS-1:0]  ir_op;
  logic [REG_BITS-1:0] ir_rx;
  logic [REG_BITS-1:0] ir_ry;

  assign ir_op = ir[IR_W-1 -: OP_BITS];
  assign ir_rx = ir[2*REG_BITS-1 -: REG_BITS];
  assign ir_ry = ir[REG_BITS-1:0];

  // Step timing and the wait-state exit condition.
  always_comb begin
    step_last  = (cnt_q == CNT_LAST);
    wait_state = (state_q == S_F_SRC) || (state_q == S_IMM_SRC);
    advance    = step_last && (!wait_state || din_valid);
  end

  // Next-state, field latching, step counter and retire pulse.
  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    opcode_d = opcode_q;
    cnt_d    = step_last ? '0 : cnt_q + CNT_W'(1);
    done_d   = advance && ((state_q == S_WB_LD) || (state_q == S_IMM_LD));
    if (advance) begin
      case (state_q)
        S_IDLE:    state_d = S_F_SRC;
        S_F_SRC:   state_d = S_F_LD;
        S_F_LD:    state_d = S_DECODE;
        S_DECODE: begin
          rx_d     = ir_rx;
          ry_d     = ir_ry;
          opcode_d = ir_op;
          if (ir_op == OP_MV) begin
            state_d = S_OP_SRC;
          end else if (ir_op == OP_MVI) begin
            state_d = S_IMM_SRC;
          end else begin
            state_d = S_A_SRC;
          end
        end
        S_IMM_SRC: state_d = S_IMM_LD;
        S_IMM_LD:  state_d = S_F_SRC;
        S_A_SRC:   state_d = S_A_LD;
        S_A_LD:    state_d = S_OP_SRC;
        // mv writes back directly; ALU ops go through A/G.
        S_OP_SRC:  state_d = (opcode_q == OP_MV) ? S_WB_LD : S_EXEC;
        S_EXEC:    state_d = S_G_SRC;
        S_G_SRC:   state_d = S_WB_LD;
        S_WB_LD:   state_d = S_F_SRC;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Bus outputs for the state being entered, so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    addr_d   = '0;
    val_d    = 1'b0;
    bus_en_d = 1'b0;
    aluen_d  = 1'b0;
    case (state_d)
      S_F_SRC: begin
        addr_d = ADDR_DIN; val_d = 1'b1; bus_en_d = 1'b1;
      end
      S_F_LD: begin
        addr_d = ADDR_IR; val_d = 1'b0; bus_en_d = 1'b1;
      end
      S_IMM_SRC: begin
        addr_d = ADDR_DIN; val_d = 1'b1; bus_en_d = 1'b1;
      end
      S_IMM_LD: begin
        addr_d = {1'b0, rx_d}; val_d = 1'b0; bus_en_d = 1'b1;
      end
      S_A_SRC: begin
        addr_d = {1'b0, rx_d}; val_d = 1'b1; bus_en_d = 1'b1;
      end
      S_A_LD: begin
        addr_d = ADDR_A; val_d = 1'b0; bus_en_d = 1'b1;
      end
      S_OP_SRC: begin
        addr_d = {1'b0, ry_d}; val_d = 1'b1; bus_en_d = 1'b1;
      end
      S_EXEC: begin
        aluen_d = 1'b1;
      end
      S_G_SRC: begin
        addr_d = ADDR_G; val_d = 1'b1; bus_en_d = 1'b1;
      end
      S_WB_LD: begin
        addr_d = {1'b0, rx_d}; val_d = 1'b0; bus_en_d = 1'b1;
      end
      default: begin
        addr_d   = '0;
        val_d    = 1'b0;
        bus_en_d = 1'b0;
        aluen_d  = 1'b0;
      end
    endcase
  end

  // State, counter, latched fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      val_q    <= 1'b0;
      bus_en_q <= 1'b0;
      aluen_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      val_q    <= val_d;
      bus_en_q <= bus_en_d;
      aluen_q  <= aluen_d;
      done_q   <= done_d;
    end
  end

  // The acknowledge marks the exit clock of a wait step.
  always_comb begin
    din_ack = wait_state && step_last && din_valid;
  end

  assign addr       = addr_q;
  assign val        = val_q;
  assign bus_en     = bus_en_q;
  assign opcode     = opcode_q;
  assign aluen      = aluen_q;
  assign instr_done = done_q;
  assign dbg_state  = state_q;

endmodule
